// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO (Gray write pointer, registered full/occupancy).
// Optional almost-full flag is built only when FIFO_WPTR_ALMOST_FULL_EN is defined; otherwise wafull is tied to 0.
module fifo_wptr_full #(
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wen,
    output logic              wfull,
    output logic [ADDR_W:0]   wcount,
    output logic              wafull
);

    if (ADDR_W < 2 || AF_MARGIN < 0 || AF_MARGIN > (1 << ADDR_W)) begin : g_bad_params
        $error("fifo_wptr_full: ADDR_W must be >= 2 and AF_MARGIN within 0..2**ADDR_W");
    end

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] wcount_next;
    logic            wfull_next;

    assign wen   = winc & ~wfull & ~rst;
    assign waddr = wbin[ADDR_W-1:0];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    always_comb begin
        wbin_next   = wbin + {{ADDR_W{1'b0}}, wen};
        wgray_next  = (wbin_next >> 1) ^ wbin_next;
        wcount_next = wbin_next - rbin;
        wfull_next  = (wgray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wcount <= '0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            wfull  <= wfull_next;
            wcount <= wcount_next;
        end
    end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'((1 << ADDR_W) - AF_MARGIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (wcount_next >= AF_LEVEL);
        end
    end
`else
    assign wafull = 1'b0;
`endif

endmodule
